// File: rtl/coef_ram_ctrl_if.sv
// Bundle of coefficient-update, SRAM-port and FIR-readback signals of coef_ram_ctrl.
// Latency: none, wires only.
// Backpressure: none; master is the controller, slave is its environment (SRAM, FIR, updater).
interface coef_ram_ctrl_if;
   logic        iCoefUpdate;
   logic        iCoefDataVld;
   logic [15:0] iCoefData;
   logic        iFirStart;
   logic        oCsnRam;
   logic        oWrnRam;
   logic [3:0]  oAddrRam;
   logic [15:0] oWrDtRam;
   logic [15:0] iRdDtRam;
   logic [15:0] oCoef;
   logic        oCoefVld;
   logic        oCoefLast;
   logic        oLoadDone;
   logic        oBusy;

   modport master (
      input  iCoefUpdate, iCoefDataVld, iCoefData, iFirStart, iRdDtRam,
      output oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
      output oCoef, oCoefVld, oCoefLast, oLoadDone, oBusy
   );

   modport slave (
      output iCoefUpdate, iCoefDataVld, iCoefData, iFirStart, iRdDtRam,
      input  oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
      input  oCoef, oCoefVld, oCoefLast, oLoadDone, oBusy
   );
endinterface

// File: rtl/coef_ram_ctrl.sv
// Owns the 10x16 coefficient SP-SRAM: loads 10 taps from the update stream, reads them back as a burst.
// Latency: write presented 1 cycle after its beat; first coefficient valid 2 cycles after iFirStart is sampled.
// Backpressure: none downstream; write gaps via iCoefDataVld=0. COEF_SYMMETRIC_EN: burst is 1..10 then 10..1.
module coef_ram_ctrl (
   input  logic iClk_12M,
   input  logic iRst,
   coef_ram_ctrl_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t      state_q, state_d;
   logic [3:0]  wr_idx_q, wr_idx_d;
   logic [3:0]  rd_idx_q, rd_idx_d;

   // Registered SRAM port and readback pipeline
   logic        csn_q, wrn_q, rd_last_q;
   logic [3:0]  addr_q;
   logic [15:0] wdat_q;
   logic        coef_vld_q, coef_last_q, wr_done_q, load_done_q;

   // Next access to present (registered at the coming edge)
   logic        acc_csn, acc_wrn, acc_last, acc_wr_last;
   logic [3:0]  acc_addr;
   logic [15:0] acc_wdat;

   logic        rd_issue, rd_pending, start_ok, rd_go, rd_final;
   logic [3:0]  rd_cur_idx, rd_nxt_idx;

   assign rd_issue   = ~csn_q & wrn_q;
   assign rd_pending = rd_issue | coef_vld_q;
   // A new burst is held off until the previous one has fully drained (oBusy low).
   assign start_ok   = bus.iFirStart & ~rd_pending;
   // The first read address is launched straight from IDLE so address 1 appears right after the start edge.
   assign rd_go      = (state_q == S_READ) |
                       ((state_q == S_IDLE) & ~bus.iCoefUpdate & start_ok);
   assign rd_cur_idx = (state_q == S_READ) ? rd_idx_q : 4'd1;

`ifdef COEF_SYMMETRIC_EN
   logic desc_q, rd_cur_desc, rd_nxt_desc;
   assign rd_cur_desc = (state_q == S_READ) & desc_q;

   // Up-then-down address walk: 1..10, then 10..1, ending on the second copy of address 1
   always_comb begin
      rd_final    = rd_cur_desc & (rd_cur_idx == 4'd1);
      rd_nxt_desc = rd_cur_desc | (rd_cur_idx == 4'd10);
      if (rd_cur_desc)
         rd_nxt_idx = rd_cur_idx - 4'd1;
      else if (rd_cur_idx == 4'd10)
         rd_nxt_idx = 4'd10;
      else
         rd_nxt_idx = rd_cur_idx + 4'd1;
   end

   // Direction flag advances with every presented read
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst)
         desc_q <= 1'b0;
      else if (rd_go)
         desc_q <= rd_nxt_desc;
   end
`else
   // Single ascending walk 1..10
   always_comb begin
      rd_final   = (rd_cur_idx == 4'd10);
      rd_nxt_idx = rd_cur_idx + 4'd1;
   end
`endif

   // State and index registers
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         state_q  <= S_IDLE;
         wr_idx_q <= 4'd1;
         rd_idx_q <= 4'd1;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // Next-state: update beats a simultaneous start; starts outside IDLE are dropped
   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      if (rd_go) rd_idx_d = rd_nxt_idx;
      case (state_q)
         S_IDLE: begin
            if (bus.iCoefUpdate) begin
               state_d  = S_WRITE;
               wr_idx_d = 4'd1;
            end else if (start_ok) begin
               state_d = S_READ;
            end
         end
         S_WRITE: begin
            if (bus.iCoefDataVld) begin
               if (wr_idx_q == 4'd10) begin
                  state_d  = S_IDLE;
                  wr_idx_d = 4'd1;
               end else begin
                  wr_idx_d = wr_idx_q + 4'd1;
               end
            end
         end
         S_READ: begin
            if (rd_final) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: SRAM access to present after the coming edge, idle values otherwise
   always_comb begin
      acc_csn     = 1'b1;
      acc_wrn     = 1'b1;
      acc_addr    = 4'd0;
      acc_wdat    = 16'd0;
      acc_last    = 1'b0;
      acc_wr_last = 1'b0;
      if (rd_go) begin
         acc_csn  = 1'b0;
         acc_addr = rd_cur_idx;
         acc_last = rd_final;
      end else if ((state_q == S_WRITE) && bus.iCoefDataVld) begin
         acc_csn     = 1'b0;
         acc_wrn     = 1'b0;
         acc_addr    = wr_idx_q;
         acc_wdat    = bus.iCoefData;
         acc_wr_last = (wr_idx_q == 4'd10);
      end
   end

   // SRAM port registers plus the read-valid, last and load-done delay lines
   always_ff @(posedge iClk_12M or posedge iRst) begin
      if (iRst) begin
         csn_q       <= 1'b1;
         wrn_q       <= 1'b1;
         addr_q      <= 4'd0;
         wdat_q      <= 16'd0;
         rd_last_q   <= 1'b0;
         coef_vld_q  <= 1'b0;
         coef_last_q <= 1'b0;
         wr_done_q   <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         csn_q       <= acc_csn;
         wrn_q       <= acc_wrn;
         addr_q      <= acc_addr;
         wdat_q      <= acc_wdat;
         rd_last_q   <= acc_last;
         coef_vld_q  <= rd_issue;
         coef_last_q <= rd_issue & rd_last_q;
         wr_done_q   <= acc_wr_last;
         load_done_q <= wr_done_q;
      end
   end

   assign bus.oCsnRam   = csn_q;
   assign bus.oWrnRam   = wrn_q;
   assign bus.oAddrRam  = addr_q;
   assign bus.oWrDtRam  = wdat_q;
   assign bus.oCoef     = bus.iRdDtRam;
   assign bus.oCoefVld  = coef_vld_q;
   assign bus.oCoefLast = coef_last_q;
   assign bus.oLoadDone = load_done_q;
   assign bus.oBusy     = (state_q != S_IDLE) | rd_pending;

endmodule

// File: tb/tb_coef_ram_ctrl.sv
// Directed bench for coef_ram_ctrl with a behavioural SRAM and write/read scoreboards.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: none; every wait is a bounded cycle loop.
module tb_coef_ram_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   coef_ram_ctrl_if bus();
   coef_ram_ctrl dut (.iClk_12M(clk), .iRst(rst), .bus(bus));

   // Behavioural SP-SRAM with registered read data
   logic [15:0] mem [0:15];
   logic [15:0] rd_q;
   always @(posedge clk) begin
      if (!bus.oCsnRam) begin
         if (!bus.oWrnRam) mem[bus.oAddrRam] <= bus.oWrDtRam;
         else              rd_q <= mem[bus.oAddrRam];
      end
   end
   assign bus.iRdDtRam = rd_q;

   int checks = 0;
   int errors = 0;
   logic [15:0] coefs [1:10];
   logic [19:0] wq [$];
   logic [15:0] rq [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input string tag, input logic [15:0] base, input bit gaps, input int start_at);
      int nbeat, rd_strobes, done_cnt, done_k, gap_bad;
      bit beat;
      logic [19:0] w;
      nbeat = 0; rd_strobes = 0; done_cnt = 0; done_k = 0; gap_bad = 0;
      bus.iCoefUpdate = 1'b1;
      bus.iFirStart   = (start_at == 0);
      tick();
      bus.iCoefUpdate = 1'b0;
      bus.iFirStart   = 1'b0;
      check({tag, " busy_after_update"}, bus.oBusy, 1);
      check({tag, " no_strobe_on_entry"}, bus.oCsnRam, 1);
      for (int k = 1; k <= 24; k++) begin
         bus.iFirStart = (k == start_at);
         beat = (nbeat < 10) && (!gaps || k[0]);
         if (beat) begin
            bus.iCoefDataVld = 1'b1;
            bus.iCoefData    = base + 16'(nbeat);
            coefs[nbeat + 1] = base + 16'(nbeat);
            wq.push_back({4'(nbeat + 1), base + 16'(nbeat)});
            nbeat++;
         end else begin
            bus.iCoefDataVld = 1'b0;
            bus.iCoefData    = 16'h0;
         end
         tick();
         if (!bus.oCsnRam && bus.oWrnRam) rd_strobes++;
         if (!beat && bus.oCsnRam !== 1'b1) gap_bad++;
         if (!bus.oCsnRam && !bus.oWrnRam && wq.size() != 0) begin
            w = wq.pop_front();
            check({tag, " wr_addr"}, bus.oAddrRam, w[19:16]);
            check({tag, " wr_data"}, bus.oWrDtRam, w[15:0]);
         end
         if (bus.oLoadDone) begin
            done_cnt++;
            done_k = k;
         end
      end
      bus.iFirStart    = 1'b0;
      bus.iCoefDataVld = 1'b0;
      check({tag, " writes_left"}, wq.size(), 0);
      check({tag, " read_strobes"}, rd_strobes, 0);
      check({tag, " gap_strobes"}, gap_bad, 0);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " done_cycle"}, done_k, gaps ? 20 : 11);
      check({tag, " busy_end"}, bus.oBusy, 0);
      for (int a = 1; a <= 10; a++) check({tag, " ram_word"}, mem[a], coefs[a]);
   endtask

   task automatic read_burst(input string tag, input int abort_beat);
      int nv, first_k, last_k, busy_k, nexp;
      logic [15:0] e;
      rq.delete();
      for (int i = 1; i <= 10; i++) rq.push_back(coefs[i]);
`ifdef COEF_SYMMETRIC_EN
      for (int i = 10; i >= 1; i--) rq.push_back(coefs[i]);
`endif
      nexp = rq.size();
      nv = 0; first_k = 0; last_k = 0; busy_k = 0;
      bus.iFirStart = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         bus.iFirStart = 1'b0;
         if (bus.oBusy) busy_k = k;
         if (bus.oCoefVld) begin
            nv++;
            if (first_k == 0) first_k = k;
            last_k = k;
            if (rq.size() != 0) begin
               e = rq.pop_front();
               check({tag, " coef"}, bus.oCoef, e);
               check({tag, " last_flag"}, bus.oCoefLast, rq.size() == 0);
            end
            if (nv == abort_beat) begin
               rst = 1'b1;
               #1;
               check({tag, " rst_csn"}, bus.oCsnRam, 1);
               check({tag, " rst_addr"}, bus.oAddrRam, 0);
               check({tag, " rst_vld"}, bus.oCoefVld, 0);
               check({tag, " rst_last"}, bus.oCoefLast, 0);
               check({tag, " rst_busy"}, bus.oBusy, 0);
               tick();
               check({tag, " rst_csn_next_edge"}, bus.oCsnRam, 1);
               rst = 1'b0;
               tick();
               check({tag, " post_rst_csn"}, bus.oCsnRam, 1);
               check({tag, " post_rst_vld"}, bus.oCoefVld, 0);
               rq.delete();
               return;
            end
         end
      end
      check({tag, " beats"}, nv, nexp);
      check({tag, " first_beat_cycle"}, first_k, 2);
      check({tag, " last_beat_cycle"}, last_k, 1 + nexp);
      check({tag, " busy_until_vld_falls"}, busy_k, 1 + nexp);
   endtask

   initial begin
      rst              = 1'b1;
      bus.iCoefUpdate  = 1'b0;
      bus.iCoefDataVld = 1'b0;
      bus.iCoefData    = 16'h0;
      bus.iFirStart    = 1'b0;
      tick();
      tick();
      check("reset csn", bus.oCsnRam, 1);
      check("reset wrn", bus.oWrnRam, 1);
      check("reset addr", bus.oAddrRam, 0);
      check("reset wdat", bus.oWrDtRam, 0);
      check("reset vld", bus.oCoefVld, 0);
      check("reset last", bus.oCoefLast, 0);
      check("reset done", bus.oLoadDone, 0);
      check("reset busy", bus.oBusy, 0);
      rst = 1'b0;
      tick();

      // Update and start together, then a contiguous load of 1..10
      load("ld_contig", 16'h0001, 1'b0, 0);
      read_burst("rd_inc", 0);

      // Gapped load of FFF6..FFFF with a start pulse in the middle
      load("ld_gap", 16'hFFF6, 1'b1, 8);
      read_burst("rd_neg", 0);

      // Reset on the fourth beat, then a clean full burst from untouched SRAM
      read_burst("rd_abort", 4);
      read_burst("rd_after_rst", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
